// File: rtl/dma_chan_sched_pkg.sv
// Shared types for the multi-channel DMA front-end scheduler.
// Descriptor/status/error structs plus scheduler FSM and completion codes.
package dma_chan_sched_pkg;

   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [31:0] num_bytes;
   } s_dma_desc_t;

   typedef struct packed {
      logic active;
      logic done;
      logic error;
   } s_dma_status_t;

   typedef struct packed {
      logic        src;
      logic [31:0] addr;
   } s_dma_error_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BUSY,
      ST_CPL
   } e_dma_sched_state_t;

   typedef enum logic [1:0] {
      CPL_OK      = 2'b00,
      CPL_DMA_ERR = 2'b01,
      CPL_REJECT  = 2'b10,
      CPL_TIMEOUT = 2'b11
   } e_dma_cpl_status_t;

   localparam int unsigned BEAT_LSB = 6;

   // Engine moves whole 64-byte beats only.
   function automatic logic desc_reject(input s_dma_desc_t d);
      return (d.num_bytes == '0) ||
             (d.num_bytes[BEAT_LSB-1:0] != '0);
   endfunction

endpackage

// File: rtl/dma_chan_sched_if.sv
// Requester-side bundle: per-channel descriptor handshake and completions.
// master = requesters / command layer, slave = dma_chan_sched.
interface dma_chan_sched_if
   import dma_chan_sched_pkg::*;
#(
   parameter int NUM_CH = 4
) ();

   logic              [NUM_CH-1:0] req_valid_i;
   s_dma_desc_t       [NUM_CH-1:0] req_desc_i;
   logic              [NUM_CH-1:0] req_ready_o;
   logic              [NUM_CH-1:0] cpl_valid_o;
   e_dma_cpl_status_t              cpl_status_o;
   s_dma_error_t                   cpl_err_src_o;

   modport master (
      output req_valid_i,
      output req_desc_i,
      input  req_ready_o,
      input  cpl_valid_o,
      input  cpl_status_o,
      input  cpl_err_src_o
   );

   modport slave (
      input  req_valid_i,
      input  req_desc_i,
      output req_ready_o,
      output cpl_valid_o,
      output cpl_status_o,
      output cpl_err_src_o
   );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter: searches upward from the last winner, one-hot grant.
// Pointer moves to the winner only on an accept strobe.
module dma_rr_arbiter #(
   parameter int NUM_CH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_en,
   input  logic [NUM_CH-1:0]         i_req,
   input  logic                      i_accept,
   output logic [NUM_CH-1:0]         o_grant,
   output logic [$clog2(NUM_CH)-1:0] o_idx
);

   localparam int CHW = $clog2(NUM_CH);

   logic [CHW-1:0] r_last;
   logic [CHW-1:0] w_idx;
   logic           w_found;
   int             w_k;

   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_k     = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         w_k = (int'(r_last) + i) % NUM_CH;
         if (!w_found && i_req[CHW'(w_k)]) begin
            w_found = 1'b1;
            w_idx   = CHW'(w_k);
         end
      end
   end

   always_comb begin
      o_grant = '0;
      if (i_en && w_found) begin
         o_grant[w_idx] = 1'b1;
      end
   end

   assign o_idx = w_idx;

   // Reset to the top channel so channel 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= CHW'(NUM_CH - 1);
      end else if (i_accept) begin
         r_last <= w_idx;
      end
   end

endmodule

// File: rtl/dma_chan_sched.sv
// Multi-channel scheduler in front of the single DMA engine.
// Optional watchdog: define DMA_SCHED_TIMEOUT_EN.
module dma_chan_sched
   import dma_chan_sched_pkg::*;
#(
   parameter int NUM_CH = 4
`ifdef DMA_SCHED_TIMEOUT_EN
   ,
   parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   dma_chan_sched_if.slave           bus,
   output logic                      dma_go_o,
   output s_dma_desc_t               dma_desc_o,
   input  s_dma_status_t             dma_stats_i,
   input  s_dma_error_t              dma_error_i,
   output logic                      busy_o,
   output logic [$clog2(NUM_CH)-1:0] cur_ch_o
);

   localparam int CHW = $clog2(NUM_CH);

   e_dma_sched_state_t r_state;
   e_dma_sched_state_t w_state_nx;
   e_dma_cpl_status_t  r_status;
   e_dma_cpl_status_t  w_status_nx;
   s_dma_error_t       r_err_src;
   s_dma_error_t       w_err_nx;
   s_dma_desc_t        r_desc;
   s_dma_desc_t        w_sel_desc;
   logic [CHW-1:0]     r_cur_ch;
   logic [CHW-1:0]     w_idx;
   logic [NUM_CH-1:0]  w_grant;
   logic               w_hs;
   logic               w_rej;
   logic               w_tmo;

   dma_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_en     (r_state == ST_IDLE),
      .i_req    (bus.req_valid_i),
      .i_accept (w_hs),
      .o_grant  (w_grant),
      .o_idx    (w_idx)
   );

   assign w_hs       = |w_grant;
   assign w_sel_desc = bus.req_desc_i[w_idx];
   assign w_rej      = desc_reject(w_sel_desc);

`ifdef DMA_SCHED_TIMEOUT_EN
   logic [31:0] r_wdog;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog <= '0;
      end else if (w_hs) begin
         r_wdog <= '0;
      end else if (r_state == ST_ISSUE ||
                   r_state == ST_BUSY) begin
         r_wdog <= r_wdog + 32'd1;
      end
   end

   // Leaves on the cycle the count would reach the limit.
   assign w_tmo = (r_state == ST_ISSUE ||
                   r_state == ST_BUSY) &&
                  (r_wdog == TIMEOUT_CYC - 32'd1);
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_state_nx  = r_state;
      w_status_nx = r_status;
      w_err_nx    = r_err_src;
      unique case (r_state)
         ST_IDLE: begin
            if (w_hs) begin
               w_err_nx = '0;
               if (w_rej) begin
                  w_state_nx  = ST_CPL;
                  w_status_nx = CPL_REJECT;
               end else begin
                  w_state_nx  = ST_ISSUE;
                  w_status_nx = CPL_OK;
               end
            end
         end
         ST_ISSUE: begin
            if (dma_stats_i.active) begin
               w_state_nx = ST_BUSY;
            end else if (w_tmo) begin
               w_state_nx  = ST_CPL;
               w_status_nx = CPL_TIMEOUT;
            end
         end
         ST_BUSY: begin
            if (dma_stats_i.error) begin
               w_state_nx  = ST_CPL;
               w_status_nx = CPL_DMA_ERR;
               w_err_nx    = dma_error_i;
            end else if (dma_stats_i.done) begin
               w_state_nx  = ST_CPL;
               w_status_nx = CPL_OK;
            end else if (w_tmo) begin
               w_state_nx  = ST_CPL;
               w_status_nx = CPL_TIMEOUT;
            end
         end
         ST_CPL: begin
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_status  <= CPL_OK;
         r_err_src <= '0;
         r_desc    <= '0;
         r_cur_ch  <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_status  <= w_status_nx;
         r_err_src <= w_err_nx;
         if (w_hs) begin
            r_desc   <= w_sel_desc;
            r_cur_ch <= w_idx;
         end
      end
   end

   always_comb begin
      bus.cpl_valid_o   = '0;
      bus.cpl_status_o  = CPL_OK;
      bus.cpl_err_src_o = '0;
      if (r_state == ST_CPL) begin
         bus.cpl_valid_o[r_cur_ch] = 1'b1;
         bus.cpl_status_o          = r_status;
         bus.cpl_err_src_o         = r_err_src;
      end
   end

   assign bus.req_ready_o = w_grant;
   assign dma_go_o   = (r_state == ST_ISSUE);
   assign dma_desc_o = (r_state == ST_ISSUE) ? r_desc : '0;
   assign busy_o     = (r_state != ST_IDLE);
   assign cur_ch_o   = r_cur_ch;

endmodule

// File: tb/tb_dma_chan_sched.sv
// Bench for dma_chan_sched: directed table, corner sequences, random traffic.
// The engine is emulated here; expectations come from a round-robin model.
module tb_dma_chan_sched;
   import dma_chan_sched_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          go;
   s_dma_desc_t   ddesc;
   s_dma_status_t stats;
   s_dma_error_t  eerr;
   logic          busy;
   logic [1:0]    cur;

   int            nvec = 0;
   int            nerr = 0;
   int            m_last = 3;
   s_dma_desc_t   d_desc [4];

   typedef struct {
      logic [3:0]        mask;
      logic [31:0]       nb;
      int                oc;
      int                exp_ch;
      e_dma_cpl_status_t exp_st;
   } vec_t;

   vec_t tbl [7];

   always #5 clk = ~clk;

   dma_chan_sched_if #(.NUM_CH(4)) bus ();

   dma_chan_sched #(
      .NUM_CH (4)
`ifdef DMA_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (32'd100)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dma_go_o    (go),
      .dma_desc_o  (ddesc),
      .dma_stats_i (stats),
      .dma_error_i (eerr),
      .busy_o      (busy),
      .cur_ch_o    (cur)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm,
                      input logic [127:0] a,
                      input logic [127:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   task automatic load_descs();
      for (int c = 0; c < 4; c++) begin
         bus.req_desc_i[2'(c)] = d_desc[c];
      end
   endtask

   // oc: 0 done, 1 error, 2 error+done together
   task automatic run_txn(input logic [3:0] mask,
                          input int oc,
                          input s_dma_error_t errv,
                          input int da,
                          input int db,
                          input int ch,
                          input e_dma_cpl_status_t st);
      s_dma_error_t xerr;
      xerr = (st == CPL_DMA_ERR) ? errv : '0;
      bus.req_valid_i = mask;
      load_descs();
      #1;
      chk("grant", 128'(bus.req_ready_o), 128'(4'b0001 << ch));
      tick();
      bus.req_valid_i[2'(ch)] = 1'b0;
      #1;
      if (st != CPL_REJECT) begin
         chk("go_issue", 128'(go), 128'(1'b1));
         chk("desc_issue", 128'(ddesc), 128'(d_desc[ch]));
         chk("cur_ch", 128'(cur), 128'(ch));
         repeat (da) begin
            tick();
            #1;
            chk("go_hold", 128'(go), 128'(1'b1));
            chk("desc_hold", 128'(ddesc), 128'(d_desc[ch]));
         end
         stats.active = 1'b1;
         tick();
         stats.active = 1'b0;
         eerr = errv;
         #1;
         chk("go_busy", 128'(go), 128'(1'b0));
         chk("desc_busy", 128'(ddesc), 128'(0));
         repeat (db) begin
            tick();
            #1;
            chk("no_early_cpl", 128'(bus.cpl_valid_o), 128'(0));
         end
         stats.done  = (oc != 1);
         stats.error = (oc != 0);
         tick();
         stats.done  = 1'b0;
         stats.error = 1'b0;
         #1;
      end
      chk("cpl_valid", 128'(bus.cpl_valid_o), 128'(4'b0001 << ch));
      chk("cpl_status", 128'(bus.cpl_status_o), 128'(st));
      chk("cpl_err", 128'(bus.cpl_err_src_o), 128'(xerr));
      chk("go_cpl", 128'(go), 128'(1'b0));
      chk("no_grant_cpl", 128'(bus.req_ready_o), 128'(0));
      tick();
      eerr = '0;
   endtask

   task automatic rand_phase(input int n);
      logic [3:0]        pend;
      int                w;
      int                k;
      int                oc;
      logic [31:0]       nb;
      s_dma_error_t      ev;
      e_dma_cpl_status_t st;
      pend = '0;
      for (int t = 0; t < n; t++) begin
         for (int c = 0; c < 4; c++) begin
            if (!pend[c] && ($urandom_range(1, 0) == 1 ||
                             (pend == '0 && c == 3))) begin
               case ($urandom_range(3, 0))
                  0: nb = 32'd0;
                  1: nb = 32'($urandom_range(64, 1)) * 64 +
                          32'($urandom_range(63, 1));
                  default: nb = 32'($urandom_range(64, 1)) * 64;
               endcase
               d_desc[c].src_addr  = $urandom;
               d_desc[c].dst_addr  = $urandom;
               d_desc[c].num_bytes = nb;
               pend[c] = 1'b1;
            end
         end
         w = -1;
         for (int i = 1; i <= 4; i++) begin
            k = (m_last + i) % 4;
            if (w < 0 && pend[k]) w = k;
         end
         nb = d_desc[w].num_bytes;
         oc = $urandom_range(2, 0);
         ev.src  = 1'($urandom_range(1, 0));
         ev.addr = $urandom;
         if (nb == 0 || nb % 64 != 0) st = CPL_REJECT;
         else if (oc != 0)            st = CPL_DMA_ERR;
         else                         st = CPL_OK;
         run_txn(pend, oc, ev, $urandom_range(3, 0),
                 $urandom_range(3, 0), w, st);
         pend[w] = 1'b0;
         m_last = w;
      end
      bus.req_valid_i = '0;
   endtask

   initial begin
      tbl[0] = '{4'b1111, 32'd256,  0, 0, CPL_OK};
      tbl[1] = '{4'b1110, 32'd512,  0, 1, CPL_OK};
      tbl[2] = '{4'b1100, 32'd64,   2, 2, CPL_DMA_ERR};
      tbl[3] = '{4'b1101, 32'd4096, 0, 3, CPL_OK};
      tbl[4] = '{4'b0101, 32'h41,   0, 0, CPL_REJECT};
      tbl[5] = '{4'b0100, 32'd0,    0, 2, CPL_REJECT};
      tbl[6] = '{4'b0110, 32'd128,  1, 1, CPL_DMA_ERR};

      for (int c = 0; c < 4; c++) begin
         d_desc[c].src_addr  = 32'h1100_0100 + 32'(c) * 32'h1000;
         d_desc[c].dst_addr  = 32'h1400_0100 + 32'(c) * 32'h1000;
         d_desc[c].num_bytes = 32'd256;
      end
      bus.req_valid_i = '0;
      bus.req_desc_i  = '0;
      stats = '0;
      eerr  = '0;

      repeat (2) tick();
      #1;
      chk("rst_ready", 128'(bus.req_ready_o), 128'(0));
      chk("rst_cpl", 128'(bus.cpl_valid_o), 128'(0));
      chk("rst_status", 128'(bus.cpl_status_o), 128'(0));
      chk("rst_err", 128'(bus.cpl_err_src_o), 128'(0));
      chk("rst_go", 128'(go), 128'(0));
      chk("rst_desc", 128'(ddesc), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_cur", 128'(cur), 128'(0));
      rst = 1'b0;

      for (int r = 0; r < 7; r++) begin
         d_desc[tbl[r].exp_ch].num_bytes = tbl[r].nb;
         run_txn(tbl[r].mask, tbl[r].oc,
                 '{src: 1'b1, addr: 32'hDEAD_0000 + 32'(r)},
                 r % 3, (r + 1) % 3, tbl[r].exp_ch, tbl[r].exp_st);
      end
      bus.req_valid_i = '0;
      for (int c = 0; c < 4; c++) d_desc[c].num_bytes = 32'd256;
      load_descs();

      // Watchdog: ch3 is next after ch1; the engine never goes active.
      bus.req_valid_i = 4'b1000;
      #1;
      chk("wd_grant", 128'(bus.req_ready_o), 128'(4'b1000));
      tick();
`ifdef DMA_SCHED_TIMEOUT_EN
      bus.req_valid_i = 4'b0001;
      repeat (99) tick();
      #1;
      chk("wd_pre", 128'(bus.cpl_valid_o), 128'(0));
      chk("wd_go_pre", 128'(go), 128'(1'b1));
      tick();
      #1;
      chk("wd_cpl", 128'(bus.cpl_valid_o), 128'(4'b1000));
      chk("wd_status", 128'(bus.cpl_status_o), 128'(CPL_TIMEOUT));
      chk("wd_go", 128'(go), 128'(1'b0));
      tick();
      #1;
      chk("wd_next", 128'(bus.req_ready_o), 128'(4'b0001));
      bus.req_valid_i = '0;
`else
      bus.req_valid_i = '0;
      repeat (150) tick();
      #1;
      chk("nowd_go", 128'(go), 128'(1'b1));
      chk("nowd_cpl", 128'(bus.cpl_valid_o), 128'(0));
      stats.active = 1'b1;
      tick();
      stats.active = 1'b0;
      stats.done = 1'b1;
      tick();
      stats.done = 1'b0;
      #1;
      chk("nowd_ok", 128'(bus.cpl_valid_o), 128'(4'b1000));
      chk("nowd_st", 128'(bus.cpl_status_o), 128'(CPL_OK));
      tick();
`endif

      // Reset while ch2 owns the engine.
      bus.req_valid_i = 4'b0100;
      #1;
      chk("mr_grant", 128'(bus.req_ready_o), 128'(4'b0100));
      tick();
      bus.req_valid_i = '0;
      stats.active = 1'b1;
      tick();
      stats.active = 1'b0;
      #1;
      chk("mr_busy", 128'(busy), 128'(1'b1));
      chk("mr_cur", 128'(cur), 128'(2));
      rst = 1'b1;
      stats.done = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mr_busy0", 128'(busy), 128'(0));
      chk("mr_cpl0", 128'(bus.cpl_valid_o), 128'(0));
      chk("mr_cur0", 128'(cur), 128'(0));
      chk("mr_go0", 128'(go), 128'(0));
      chk("mr_st0", 128'(bus.cpl_status_o), 128'(0));
      tick();
      stats.done = 1'b0;
      #1;
      chk("mr_cpl1", 128'(bus.cpl_valid_o), 128'(0));
      m_last = 3;
      run_txn(4'b1111, 0, '0, 1, 1, 0, CPL_OK);
      m_last = 0;
      bus.req_valid_i = '0;

      rand_phase(60);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
